// File: rtl/uart_top.sv
// uart_top: UART loopback. An 8-bit transmitter drives an internal serial
// line that feeds a receiver on the same clock. The frame is a start bit (0),
// the data bits LSB first, an optional even-parity bit, and a stop bit (1).
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-high reset
//   transmit     transmit request level; a rising edge starts one frame
//   TX_DATA      byte to send, captured at frame start
//   par_EN       1 = frame carries an even-parity bit
//   busy         high while a frame is being transmitted
//   RXDATA       last received byte
//   VALID_RX     last frame received without error (held)
//   PARITY_ERROR last frame had a parity mismatch (held)
//   STOP_ERROR   last frame's stop bit sampled 0 (held)
module uart_top #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_W       = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              transmit,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              par_EN,
  output logic              busy,
  output logic [DATA_W-1:0] RXDATA,
  output logic              VALID_RX,
  output logic              PARITY_ERROR,
  output logic              STOP_ERROR
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    TX_S_IDLE,
    TX_S_START,
    TX_S_DATA,
    TX_S_PARITY,
    TX_S_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_S_IDLE,
    RX_S_START,
    RX_S_DATA,
    RX_S_PARITY,
    RX_S_STOP
  } rx_state_t;

  // ---------------------------------------------------------------- TX side
  tx_state_t         tx_state_q;
  logic [CNT_W-1:0]  tx_cnt_q;
  logic [BIT_W-1:0]  tx_bit_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic              tx_par_q;
  logic              tx_paren_q;
  logic              tx_line_q;
  logic              busy_q;
  logic              trans_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_q <= TX_S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_paren_q <= 1'b0;
      tx_line_q  <= 1'b1;
      busy_q     <= 1'b0;
      trans_q    <= 1'b0;
    end else begin
      trans_q <= transmit;
      case (tx_state_q)
        TX_S_IDLE: begin
          tx_line_q <= 1'b1;
          busy_q    <= 1'b0;
          tx_cnt_q  <= '0;
          // Rising edge of the request; a level held high starts only one frame.
          if (transmit && !trans_q) begin
            tx_shift_q <= TX_DATA;
            tx_par_q   <= ^TX_DATA;
            tx_paren_q <= par_EN;
            tx_line_q  <= 1'b0;
            busy_q     <= 1'b1;
            tx_state_q <= TX_S_START;
          end
        end
        TX_S_START: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= tx_shift_q[0];
            tx_state_q <= TX_S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_S_DATA: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == BIT_LAST) begin
              if (tx_paren_q) begin
                tx_line_q  <= tx_par_q;
                tx_state_q <= TX_S_PARITY;
              end else begin
                tx_line_q  <= 1'b1;
                tx_state_q <= TX_S_STOP;
              end
            end else begin
              // Line shows the next bit while the register shifts toward it.
              tx_bit_q   <= tx_bit_q + BIT_W'(1);
              tx_line_q  <= tx_shift_q[1];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_S_PARITY: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q   <= '0;
            tx_line_q  <= 1'b1;
            tx_state_q <= TX_S_STOP;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_S_STOP: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q   <= '0;
            busy_q     <= 1'b0;
            tx_state_q <= TX_S_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        default: tx_state_q <= TX_S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX side
  rx_state_t         rx_state_q;
  logic [CNT_W-1:0]  rx_cnt_q;
  logic [BIT_W-1:0]  rx_bit_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic              rx_paren_q;
  logic              rx_parbit_q;
  logic              rx_meta_q;
  logic              rx_sync_q;
  logic              rx_prev_q;
  logic [DATA_W-1:0] rxdata_q;
  logic              valid_q;
  logic              perr_q;
  logic              serr_q;

  logic stop_perr;
  logic stop_serr;

  assign stop_perr = rx_paren_q && (rx_parbit_q != ^rx_shift_q);
  assign stop_serr = !rx_sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state_q  <= RX_S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_paren_q  <= 1'b0;
      rx_parbit_q <= 1'b0;
      // Synchronizer resets to the idle line level so no false edge follows reset.
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rxdata_q    <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
    end else begin
      rx_meta_q <= tx_line_q;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      case (rx_state_q)
        RX_S_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) begin
            rx_paren_q <= par_EN;
            rx_state_q <= RX_S_START;
          end
        end
        RX_S_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q <= '0;
            if (!rx_sync_q) begin
              rx_bit_q   <= '0;
              valid_q    <= 1'b0;
              perr_q     <= 1'b0;
              serr_q     <= 1'b0;
              rx_state_q <= RX_S_DATA;
            end else begin
              rx_state_q <= RX_S_IDLE;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_S_DATA: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_W-1:1]};
            if (rx_bit_q == BIT_LAST) begin
              rx_state_q <= rx_paren_q ? RX_S_PARITY : RX_S_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + BIT_W'(1);
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_S_PARITY: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q    <= '0;
            rx_parbit_q <= rx_sync_q;
            rx_state_q  <= RX_S_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_S_STOP: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_q   <= '0;
            rxdata_q   <= rx_shift_q;
            perr_q     <= stop_perr;
            serr_q     <= stop_serr;
            valid_q    <= !stop_perr && !stop_serr;
            rx_state_q <= RX_S_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        default: rx_state_q <= RX_S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign RXDATA       = rxdata_q;
  assign VALID_RX     = valid_q;
  assign PARITY_ERROR = perr_q;
  assign STOP_ERROR   = serr_q;

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: randomized loopback bench for uart_top with a reduced bit time.
// A queue-based reference model predicts the received byte, flag levels and
// busy duration from the frame rules (bit count times bit time).
module tb_uart_top;

  localparam int CPB = 16;

  logic       CLK;
  logic       RST;
  logic       transmit;
  logic [7:0] TX_DATA;
  logic       par_EN;
  logic       busy;
  logic [7:0] RXDATA;
  logic       VALID_RX;
  logic       PARITY_ERROR;
  logic       STOP_ERROR;

  int total;
  int bad;
  logic [7:0] sent_q[$];

  uart_top #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .transmit(transmit),
    .TX_DATA(TX_DATA),
    .par_EN(par_EN),
    .busy(busy),
    .RXDATA(RXDATA),
    .VALID_RX(VALID_RX),
    .PARITY_ERROR(PARITY_ERROR),
    .STOP_ERROR(STOP_ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_cycles(input logic p);
    return (p ? 11 : 10) * CPB;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rxdata"}, RXDATA, 0);
    check({tag, "_valid"}, VALID_RX, 0);
    check({tag, "_perr"}, PARITY_ERROR, 0);
    check({tag, "_serr"}, STOP_ERROR, 0);
  endtask

  // Sends one frame. hold keeps transmit high past the end of the frame;
  // disturb changes TX_DATA and toggles transmit while busy.
  task automatic run_frame(input logic [7:0] d, input logic p, input bit hold, input bit disturb);
    int n;
    logic valid_mid;
    logic seen_busy;
    logic [7:0] exp_d;
    @(negedge CLK);
    TX_DATA  = d;
    par_EN   = p;
    transmit = 1'b1;
    sent_q.push_back(d);
    @(negedge CLK);
    n = 0;
    valid_mid = 1'b1;
    while (busy && n < 12 * CPB) begin
      if (!hold && !disturb && n == 2) transmit = 1'b0;
      if (disturb) begin
        if (n == 3 * CPB) TX_DATA = 8'h12;
        if (n == 4 * CPB) transmit = 1'b0;
        if (n == 4 * CPB + 3) transmit = 1'b1;
        if (n == 5 * CPB) transmit = 1'b0;
      end
      if (n == CPB + 4) valid_mid = VALID_RX;
      @(negedge CLK);
      n++;
    end
    check("busy_len", n, frame_cycles(p));
    check("valid_dropped", valid_mid, 0);
    repeat (3) @(negedge CLK);
    exp_d = sent_q.pop_front();
    check("rxdata", RXDATA, exp_d);
    check("valid", VALID_RX, 1);
    check("perr", PARITY_ERROR, 0);
    check("serr", STOP_ERROR, 0);
    seen_busy = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge CLK);
      if (busy) seen_busy = 1'b1;
    end
    check("no_extra_frame", seen_busy, 0);
    check("rxdata_held", RXDATA, exp_d);
    check("valid_held", VALID_RX, 1);
    transmit = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int n;
    total    = 0;
    bad      = 0;
    RST      = 1'b1;
    transmit = 1'b0;
    TX_DATA  = 8'h00;
    par_EN   = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (4 * CPB) @(negedge CLK);
    check_idle_outputs("idle_after_reset");

    run_frame(8'h6F, 1'b1, 1'b1, 1'b0);
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    run_frame(8'h00, 1'b1, 1'b0, 1'b0);
    run_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    run_frame(8'h5A, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of the data bits.
    @(negedge CLK);
    TX_DATA  = 8'hC3;
    par_EN   = 1'b1;
    transmit = 1'b1;
    n = 0;
    while (n < 5 * CPB) begin
      @(negedge CLK);
      n++;
    end
    transmit = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge CLK);
    RST = 1'b0;
    repeat (12 * CPB) @(negedge CLK);
    check_idle_outputs("after_abort");
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_top.md
Name: uart_top

Overview:
- Self-contained UART loopback block: an 8-bit transmitter and a receiver share one clock.
- The TX serial line is wired internally to the RX serial input; no external serial pins.
- Used to verify framing, optional parity and error detection end-to-end.
- Fixed timing: 50 MHz clock, 9600 baud (5208 clocks per bit).

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud).
- DATA_W, 8, data bits per frame.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  reset; one clock, reset is asynchronous and active-high.
- transmit  input  1  transmit request (level); rising edge starts a frame.
- TX_DATA  input  8  byte to send; captured at frame start.
- par_EN  input  1  1 = frame carries an even-parity bit.
- busy  output  1  high while the transmitter is sending a frame.
- RXDATA  output  8  last received byte.
- VALID_RX  output  1  last frame received without error (held level).
- PARITY_ERROR  output  1  last frame had a parity mismatch (held level).
- STOP_ERROR  output  1  last frame's stop bit sampled 0 (held level).

Behaviour:
- Reset (asynchronous, RST=1):
  - All outputs 0; busy=0.
  - TX line idle high.
  - Both FSMs go to IDLE; all counters cleared.
  - A reset mid-frame aborts the frame, and no result is reported.
- Frame format: start bit 0, data bits LSB first, optional parity bit, stop bit 1. That is 10 bits with parity off, 11 with parity on.
- Parity is even: parity bit = XOR of the 8 data bits.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - transmit is registered, and a rising edge is detected while in IDLE.
  - On that edge: capture TX_DATA and par_EN, set busy=1, and drive the line low in the next cycle.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - PARITY is skipped when the captured par_EN=0.
  - After STOP completes: busy=0, return to IDLE, line stays high.
  - Holding transmit high produces exactly one frame.
  - A new rising edge while busy is ignored.
  - TX_DATA and par_EN changes during a frame have no effect.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - The RX input passes through a 2-flop synchronizer.
  - A falling edge in IDLE enters START and latches par_EN.
  - In START the line is resampled at CLKS_PER_BIT/2. If it is still 0, reception proceeds. If it is 1, this is a false start: return to IDLE and leave the outputs unchanged.
  - Each later bit is sampled at mid-bit, CLKS_PER_BIT cycles apart.
  - Data bits are shifted in LSB first.
- RX reporting:
  - On start-bit confirmation, clear VALID_RX, PARITY_ERROR and STOP_ERROR.
  - At the stop-bit sample: RXDATA <= assembled byte. PARITY_ERROR = (par_EN latched) and (received parity != XOR of data). STOP_ERROR = (stop sample == 0). VALID_RX = neither error.
  - All flags and RXDATA hold until the next confirmed start bit or reset. They are not pulses.
- Latency: RX result is valid about (N-0.5)*CLKS_PER_BIT + 4 cycles after the TX line falls, where N = frame bit count. That is well inside 11*CLKS_PER_BIT + 2 cycles of the transmit edge.
- Counters: bit counter 0..7; baud counter 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.

Test Plan:
- Parity-on frame: RST pulse, par_EN=1, TX_DATA=0x6F, transmit held high for 11*5208 cycles → busy high for 11*5208 cycles. One frame only. At end: RXDATA=0x6F, VALID_RX=1, PARITY_ERROR=0, STOP_ERROR=0.
- Parity-off frame: par_EN=0, TX_DATA=0xA5, transmit pulse → busy high for 10*5208 cycles. RXDATA=0xA5, VALID_RX=1, both errors 0.
- Extreme data values: send 0x00 then 0xFF with par_EN=1 → each received correctly. VALID_RX drops to 0 at the second start bit and rises again at its stop sample.
- Ignored requests: change TX_DATA to 0x12 and toggle transmit while busy=1 → the current frame is unaffected and no extra frame is sent.
- Reset mid-frame: assert RST mid-way through the data bits → outputs immediately 0 and busy=0. A subsequent 0x3C frame is received correctly.
- Reset values: with no transmit after reset → all outputs 0 indefinitely and the line stays high.
